cla_addsub_pipe: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor for the Booth multiplier datapath.
//  The operand is split into SEG-bit segments, one segment per pipeline stage, with the carry

---
 rtl/cla_addsub_pipe_if.sv | 27 ++
 rtl/cla_addsub_pipe.sv | 169 ++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// The slave side is the adder; the master side feeds operands and drains results.
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 66
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sub;
    logic             in_cin;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_sub, in_cin, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_sub, in_cin, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined two-level carry-lookahead adder/subtractor, one SEG-bit segment per stage.
// Operands travel with the beat; the carry between segments is registered.
module cla_addsub_pipe #(
    parameter int WIDTH = 66,
    parameter int SEG   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    cla_addsub_pipe_if.slave    bus
);
    localparam int NSEG = (WIDTH + SEG - 1) / SEG;
    localparam int PW   = NSEG * SEG;
    localparam int TOPW = WIDTH - (NSEG - 1) * SEG;
    localparam int NG   = SEG / 4;

    if ((SEG % 4) != 0 || SEG < 4) begin : g_bad_seg
        $error("SEG must be a positive multiple of 4");
    end

    typedef logic [PW-1:0] vec_t;

    // Returns c[0..SEG]: bit carries of one segment, all in sum-of-products form.
    function automatic logic [SEG:0] seg_carry(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           cin
    );
        logic [SEG-1:0] p;
        logic [SEG-1:0] g;
        logic [NG-1:0]  pm;
        logic [NG-1:0]  gm;
        logic [NG:0]    cg;
        logic [SEG:0]   c;
        logic           t;
        p  = a ^ b;
        g  = a & b;
        cg = '0;
        c  = '0;
        for (int m = 0; m < NG; m++) begin
            pm[m] = &p[4*m +: 4];
            gm[m] = g[4*m+3]
                  | (p[4*m+3] & g[4*m+2])
                  | (p[4*m+3] & p[4*m+2] & g[4*m+1])
                  | (p[4*m+3] & p[4*m+2] & p[4*m+1] & g[4*m]);
        end
        cg[0] = cin;
        for (int m = 0; m < NG; m++) begin
            t = cin;
            for (int k = 0; k <= m; k++) t = t & pm[k];
            cg[m+1] = t;
            for (int j = 0; j <= m; j++) begin
                t = gm[j];
                for (int k = j + 1; k <= m; k++) t = t & pm[k];
                cg[m+1] = cg[m+1] | t;
            end
        end
        for (int m = 0; m < NG; m++) begin
            for (int i = 0; i < 4; i++) begin
                t = cg[m];
                for (int k = 0; k < i; k++) t = t & p[4*m+k];
                c[4*m+i] = t;
                for (int j = 0; j < i; j++) begin
                    t = g[4*m+j];
                    for (int k = j + 1; k < i; k++) t = t & p[4*m+k];
                    c[4*m+i] = c[4*m+i] | t;
                end
            end
        end
        c[SEG] = cg[NG];
        return c;
    endfunction

    logic            en;
    logic [NSEG-1:0] vld_q, vld_d;
    logic [NSEG-1:0] c_q, c_d;
    vec_t            a_q [NSEG];
    vec_t            a_d [NSEG];
    vec_t            b_q [NSEG];
    vec_t            b_d [NSEG];
    vec_t            s_q [NSEG];
    vec_t            s_d [NSEG];
    logic            ovf_q, ovf_d;

    vec_t            src_a [NSEG];
    vec_t            src_b [NSEG];
    vec_t            src_s [NSEG];
    logic [NSEG-1:0] src_c;
    logic [NSEG-1:0] src_v;

    assign en = bus.out_ready | ~vld_q[NSEG-1];

    // Stage sources: stage 0 from the port, stage k from stage k-1.
    always_comb begin
        src_a[0] = vec_t'(bus.in_a);
        src_b[0] = vec_t'(bus.in_sub ? ~bus.in_b : bus.in_b);
        src_s[0] = '0;
        src_c[0] = bus.in_sub | bus.in_cin;
        src_v[0] = bus.in_valid;
        for (int k = 1; k < NSEG; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
            src_v[k] = vld_q[k-1];
        end
    end

    always_comb begin
        logic [SEG:0] cv;
        vec_t         ss;
        vld_d = vld_q;
        c_d   = c_q;
        ovf_d = ovf_q;
        cv    = '0;
        ss    = '0;
        for (int k = 0; k < NSEG; k++) begin
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];
        end
        if (en) begin
            for (int k = 0; k < NSEG; k++) begin
                cv = seg_carry(src_a[k][k*SEG +: SEG],
                               src_b[k][k*SEG +: SEG], src_c[k]);
                ss = src_s[k];
                ss[k*SEG +: SEG] = src_a[k][k*SEG +: SEG]
                                 ^ src_b[k][k*SEG +: SEG]
                                 ^ cv[SEG-1:0];
                a_d[k]   = src_a[k];
                b_d[k]   = src_b[k];
                s_d[k]   = ss;
                vld_d[k] = src_v[k];
                c_d[k]   = (k == NSEG - 1) ? cv[TOPW] : cv[SEG];
                if (k == NSEG - 1) begin
                    ovf_d = (src_a[k][WIDTH-1] == src_b[k][WIDTH-1])
                          & (ss[WIDTH-1] != src_a[k][WIDTH-1]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < NSEG; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = vld_q[NSEG-1];
    assign bus.out_sum   = s_q[NSEG-1][WIDTH-1:0];
    assign bus.out_cout  = c_q[NSEG-1];
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed and randomised checks of the pipelined CLA adder/subtractor.
// Main instance 66/16 (5 stages), second instance 10/4 (3 stages, 2-bit top).
module tb_cla_addsub_pipe;
    localparam int W    = 66;
    localparam int NSEG = 5;
    localparam int W2   = 10;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    cla_addsub_pipe_if #(.WIDTH(W))  bus ();
    cla_addsub_pipe_if #(.WIDTH(W2)) bus2 ();

    cla_addsub_pipe #(.WIDTH(W), .SEG(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cla_addsub_pipe #(.WIDTH(W2), .SEG(4)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ovf, cout, sum[W-1:0]}
    function automatic logic [W+1:0] ref_fn(input logic sub, input logic cin,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         ovf;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub | cin)};
        ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full};
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [95:0] t;
        int          sel;
        t   = {$urandom(), $urandom(), $urandom()};
        sel = $urandom_range(0, 3);
        if (sel == 0) return '1;
        if (sel == 1) return W'(t[15:0]);
        return t[W-1:0];
    endfunction

    function automatic logic [W+1:0] obs_main();
        return {bus.out_ovf, bus.out_cout, bus.out_sum};
    endfunction

    task automatic drive_rand();
        bus.in_sub = 1'($urandom_range(0, 1));
        bus.in_cin = 1'($urandom_range(0, 1));
        bus.in_a   = rnd_op();
        bus.in_b   = rnd_op();
    endtask

    // One isolated beat; called at #1 after a posedge with the pipe empty.
    task automatic one(input string tag, input logic sub, input logic cin,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] es, input logic ec,
                       input logic eo);
        bus.in_sub    = sub;
        bus.in_cin    = cin;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (NSEG - 2) @(posedge clk);
        #1;
        chk({tag, "_early"}, bus.out_valid, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_sum"}, bus.out_sum, es);
        chk({tag, "_cout"}, bus.out_cout, ec);
        chk({tag, "_ovf"}, bus.out_ovf, eo);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W+1:0] q[$];
        logic [W+1:0] exp;
        logic [W+1:0] prev;
        int           sent;
        int           got;
        int           seen;
        n_cmp = 0;
        n_err = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_sub     = 1'b0;
        bus.in_cin     = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_sub    = 1'b0;
        bus2.in_cin    = 1'b0;
        bus2.in_a      = '0;
        bus2.in_b      = '0;
        bus2.out_ready = 1'b1;

        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_sum", bus.out_sum, '0);
        chk("rst_out_cout", bus.out_cout, 1'b0);
        chk("rst_out_ovf", bus.out_ovf, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        one("carry_chain", 1'b0, 1'b0, '1, W'(1), '0, 1'b1, 1'b0);
        one("sub_borrow", 1'b1, 1'b0, W'(5), W'(7),
            66'h3_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        one("sub_pos", 1'b1, 1'b0, W'(7), W'(5), W'(2), 1'b1, 1'b0);
        one("add_ovf", 1'b0, 1'b0, 66'h1_FFFF_FFFF_FFFF_FFFF, W'(1),
            66'h2_0000_0000_0000_0000, 1'b0, 1'b1);
        one("seg_cross", 1'b0, 1'b0, 66'hFFFF, W'(1),
            66'h1_0000, 1'b0, 1'b0);
        one("add_cin", 1'b0, 1'b1, W'(0), W'(0), W'(1), 1'b0, 1'b0);
        one("sub_cin_ign", 1'b1, 1'b1, W'(3), W'(3), W'(0), 1'b1, 1'b0);

        // Eight back-to-back beats with a 3-cycle downstream stall.
        q.delete();
        sent = 0;
        got  = 0;
        prev = '0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            bus.out_ready = !(cyc >= 7 && cyc < 10);
            bus.in_valid  = (sent < 8);
            drive_rand();
            #1;
            if (!bus.out_ready && bus.out_valid) begin
                chk("stall_in_ready", bus.in_ready, 1'b0);
                if (cyc > 7) chk("stall_hold", obs_main(), prev);
            end
            if (bus.out_valid && bus.out_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : 'x;
                chk("stream", obs_main(), exp);
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_fn(bus.in_sub, bus.in_cin, bus.in_a, bus.in_b));
                sent++;
            end
            prev = obs_main();
            @(posedge clk); #1;
        end
        chk("stream_count", got, 8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;

        // Random valid/ready against the reference model.
        q.delete();
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
            drive_rand();
            #1;
            if (bus.out_valid && bus.out_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : 'x;
                chk("random", obs_main(), exp);
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_fn(bus.in_sub, bus.in_cin, bus.in_a, bus.in_b));
                sent++;
            end
            @(posedge clk); #1;
        end
        chk("random_count", got, 10000);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (NSEG + 1) @(posedge clk);
        #1;

        // Asynchronous reset with beats in flight.
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("rst_pre_valid", bus.out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_out_sum", bus.out_sum, '0);
        chk("arst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        chk("rst_no_ghost", seen, 0);
        one("post_rst", 1'b0, 1'b0, W'(123), W'(456), W'(579), 1'b0, 1'b0);

        // Narrow configuration: 3 stages, 2-bit top segment.
        bus2.in_a     = 10'h3FF;
        bus2.in_b     = 10'h001;
        bus2.in_sub   = 1'b0;
        bus2.in_cin   = 1'b0;
        bus2.in_valid = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("w10_early", bus2.out_valid, 1'b0);
        @(posedge clk); #1;
        chk("w10_valid", bus2.out_valid, 1'b1);
        chk("w10_sum", bus2.out_sum, 10'h000);
        chk("w10_cout", bus2.out_cout, 1'b1);
        chk("w10_ovf", bus2.out_ovf, 1'b0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
